// File: rtl/hdmi_pkg.sv
// hdmi_pkg: TMDS control tokens, channel indices and gearbox state type shared by HDMI blocks
package hdmi_pkg;
    localparam logic [9:0] TMDS_CTRL_0 = 10'h354;
    localparam logic [9:0] TMDS_CTRL_1 = 10'h0AB;
    localparam logic [9:0] TMDS_CTRL_2 = 10'h154;
    localparam logic [9:0] TMDS_CTRL_3 = 10'h2AB;
    localparam int CH_BLUE  = 0;
    localparam int CH_GREEN = 1;
    localparam int CH_RED   = 2;
    typedef enum logic {PRIME, RUN} gb_state_t;
endpackage

// File: rtl/hdmi_gearbox_if.sv
// hdmi_gearbox_if: word-in / word-out handshake bundle between TMDS encoders and serializers
interface hdmi_gearbox_if #(
    parameter int NCH = 3,
    parameter int IW  = 10,
    parameter int OW  = 8
);
    logic              i_valid;
    logic              o_ready;
    logic [NCH*IW-1:0] i_word;
    logic [NCH-1:0]    i_slip;
    logic              i_train;
    logic              o_valid;
    logic [NCH*OW-1:0] o_word;
    logic              o_underflow;
    modport master (
        output i_valid, i_word, i_slip, i_train,
        input  o_ready, o_valid, o_word, o_underflow
    );
    modport slave (
        input  i_valid, i_word, i_slip, i_train,
        output o_ready, o_valid, o_word, o_underflow
    );
endinterface

// File: rtl/hdmi_bitslip.sv
// hdmi_bitslip: per-lane runtime bit delay built from the previous and current accepted words
module hdmi_bitslip #(
    parameter int IW = 10
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_slip,
    input  logic [IW-1:0] i_word,
    output logic [IW-1:0] o_word
);
    localparam int DW = IW > 1 ? $clog2(IW) : 1;
    logic [DW-1:0] d;
    logic [IW-1:0] prev;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            d    <= '0;
            prev <= '0;
        end else begin
            if (i_slip) d <= (d == DW'(IW-1)) ? '0 : d + DW'(1);
            if (i_ce) prev <= i_word;
        end
    end
    assign o_word = IW'({prev, i_word} >> d);
endmodule

// File: rtl/hdmi_gearbox.sv
// hdmi_gearbox: NCH-lane IW-to-OW TMDS gearbox with bit-slip and training override
module hdmi_gearbox
    import hdmi_pkg::*;
#(
    parameter int NCH = 3,
    parameter int IW  = 10,
    parameter int OW  = 8,
    parameter bit OPT_BITREVERSE = 1'b0,
    parameter logic [IW-1:0] TRAIN_WORD = IW'(TMDS_CTRL_0)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    hdmi_gearbox_if.slave bus
);
    localparam int BW = 2*IW;
    localparam int FW = $clog2(BW+1);
    logic [FW-1:0] fill, fill_e, fill_n;
    logic emit, accept;
    gb_state_t state, state_n;
    logic [NCH*OW-1:0] word_n;
    assign emit       = fill >= FW'(OW);
    assign fill_e     = emit ? fill - FW'(OW) : fill;
    assign bus.o_ready = ({1'b0, fill_e} + (FW+1)'(IW) <= (FW+1)'(BW)) && !i_reset;
    assign accept     = bus.i_valid && bus.o_ready;
    assign fill_n     = fill_e + (accept ? FW'(IW) : '0);
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [IW-1:0] w, rev, pre, dly;
        logic [BW-1:0] sbuf, sbuf_n;
        assign w   = bus.i_word[c*IW +: IW];
        assign rev = {<<{w}};
        assign pre = bus.i_train ? TRAIN_WORD : (OPT_BITREVERSE ? rev : w);
        hdmi_bitslip #(.IW(IW)) u_slip (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_ce    (accept),
            .i_slip  (bus.i_slip[c]),
            .i_word  (pre),
            .o_word  (dly)
        );
        // new word lands just below the bits that survive this cycle's emit
        assign sbuf_n = (emit ? sbuf << OW : sbuf) | (accept ? {dly, {IW{1'b0}}} >> fill_e : '0);
        assign word_n[c*OW +: OW] = sbuf[BW-1 -: OW];
        always_ff @(posedge i_clk) sbuf <= i_reset ? '0 : sbuf_n;
    end
    always_comb state_n = (state == PRIME && emit) ? RUN : state;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fill            <= '0;
            state           <= PRIME;
            bus.o_valid     <= 1'b0;
            bus.o_word      <= '0;
            bus.o_underflow <= 1'b0;
        end else begin
            fill            <= fill_n;
            state           <= state_n;
            bus.o_valid     <= emit;
            bus.o_underflow <= state == RUN && !emit;
            if (emit) bus.o_word <= word_n;
        end
    end
endmodule

// File: tb/tb_hdmi_gearbox.sv
// tb_hdmi_gearbox: bit-level scoreboard bench for 10:8 and 10:10 gearbox instances
module tb_hdmi_gearbox;
    localparam int NCH = 3;
    localparam int IW  = 10;
    localparam int OW  = 8;
    localparam logic [IW-1:0] TRAIN = 10'h354;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    hdmi_gearbox_if #(.NCH(NCH), .IW(IW), .OW(OW)) bus_a ();
    hdmi_gearbox_if #(.NCH(NCH), .IW(IW), .OW(IW)) bus_b ();
    hdmi_gearbox #(.NCH(NCH), .IW(IW), .OW(OW)) dut_a (.i_clk(clk), .i_reset(rst), .bus(bus_a));
    hdmi_gearbox #(.NCH(NCH), .IW(IW), .OW(IW)) dut_b (.i_clk(clk), .i_reset(rst), .bus(bus_b));
    int n_chk = 0, n_pass = 0, wk = 0;
    bit eq [NCH][$];
    bit hist [NCH][$];
    int md [NCH];
    logic [NCH*IW-1:0] bq [$];
    logic exp_va = 0, exp_ua = 0, ran = 0, b_acc1 = 0, b_acc2 = 0, acc_a = 0, rst_prev = 1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic logic [NCH*IW-1:0] mkw(input int k);
        logic [NCH*IW-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*IW +: IW] = IW'(k*3 + c);
        return r;
    endfunction
    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            eq[c].delete();
            hist[c].delete();
            repeat (IW) hist[c].push_back(1'b0);
            md[c] = 0;
        end
        bq.delete();
        ran = 0;
    endtask
    // one clock: check registered outputs, drive next inputs, then update models
    task automatic cycle(input logic v, input logic [NCH*IW-1:0] w, input logic [NCH-1:0] s,
                         input logic t, input logic r);
        logic [OW-1:0] ea;
        logic [IW-1:0] pw;
        logic [NCH*IW-1:0] eb;
        logic emit_now, acc_b;
        int qs, l;
        @(negedge clk);
        if (rst_prev) begin
            chk("rst_word", 64'(bus_a.o_word), 64'd0);
            chk("rst_fill", 64'(dut_a.fill), 64'd0);
        end
        chk("a_valid", 64'(bus_a.o_valid), 64'(exp_va));
        chk("a_underflow", 64'(bus_a.o_underflow), 64'(exp_ua));
        if (bus_a.o_valid) for (int c = 0; c < NCH; c++) begin
            if (eq[c].size() < OW) chk("a_qdepth", 64'(eq[c].size()), 64'(OW));
            else begin
                ea = '0;
                for (int j = 0; j < OW; j++) ea = {ea[OW-2:0], eq[c].pop_front()};
                chk($sformatf("a_word_ch%0d", c), 64'(bus_a.o_word[c*OW +: OW]), 64'(ea));
            end
        end
        chk("b_valid", 64'(bus_b.o_valid), 64'(b_acc2));
        if (bus_b.o_valid) begin
            if (bq.size() == 0) chk("b_qdepth", 64'(bq.size()), 64'd1);
            else begin
                eb = bq.pop_front();
                chk("b_word", 64'(bus_b.o_word), 64'(eb));
            end
        end
        bus_a.i_valid = v; bus_a.i_word = w; bus_a.i_slip = s;   bus_a.i_train = t;
        bus_b.i_valid = v; bus_b.i_word = w; bus_b.i_slip = '0;  bus_b.i_train = t;
        rst = r;
        #1;
        qs = eq[0].size();
        emit_now = qs >= OW;
        chk("a_ready", 64'(bus_a.o_ready), 64'(!r && (qs - (emit_now ? OW : 0) + IW <= 2*IW)));
        chk("b_ready", 64'(bus_b.o_ready), 64'(!r));
        acc_a = v && bus_a.o_ready;
        acc_b = v && bus_b.o_ready;
        b_acc2 = b_acc1;
        b_acc1 = acc_b;
        rst_prev = r;
        if (r) begin
            model_reset();
            exp_va = 0; exp_ua = 0; b_acc1 = 0; b_acc2 = 0; acc_a = 0;
        end else begin
            exp_va = emit_now;
            exp_ua = ran && !emit_now;
            ran = ran | emit_now;
            if (acc_a) for (int c = 0; c < NCH; c++) begin
                pw = t ? TRAIN : w[c*IW +: IW];
                for (int j = IW-1; j >= 0; j--) hist[c].push_back(pw[j]);
                l = hist[c].size();
                for (int j = 0; j < IW; j++) eq[c].push_back(hist[c][l-IW-md[c]+j]);
            end
            for (int c = 0; c < NCH; c++) if (s[c]) md[c] = (md[c] + 1) % IW;
            if (acc_b) bq.push_back(t ? {NCH{TRAIN}} : w);
        end
    endtask
    task automatic stream(input int n, input bit use_const, input logic [NCH*IW-1:0] cw, input logic t);
        int sent = 0, guard = 0;
        while (sent < n && guard < 4*n + 20) begin
            cycle(1'b1, use_const ? cw : mkw(wk), '0, t, 1'b0);
            if (acc_a) begin sent++; wk++; end
            guard++;
        end
        if (sent != n) chk("stream_timeout", 64'(sent), 64'(n));
    endtask
    initial begin
        int na, guard;
        logic [NCH*IW-1:0] cw;
        model_reset();
        bus_a.i_valid = 0; bus_a.i_word = '0; bus_a.i_slip = '0; bus_a.i_train = 0;
        bus_b.i_valid = 0; bus_b.i_word = '0; bus_b.i_slip = '0; bus_b.i_train = 0;
        @(posedge clk);
        repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        stream(100, 0, '0, 1'b0);
        na = 0;
        repeat (50) begin
            cycle(1'b1, mkw(wk), '0, 1'b0, 1'b0);
            if (acc_a) begin na++; wk++; end
        end
        chk("a_accept_rate", 64'(na), 64'd40);
        stream(850, 0, '0, 1'b0);
        guard = 0;
        while ((eq[0].size() - (exp_va ? OW : 0)) != 12 && guard < 20) begin
            cycle(1'b1, mkw(wk), '0, 1'b0, 1'b0);
            if (acc_a) wk++;
            guard++;
        end
        chk("fill12_reached", 64'(eq[0].size() - (exp_va ? OW : 0)), 64'd12);
        cycle(1'b1, mkw(wk), '0, 1'b0, 1'b1);
        stream(30, 0, '0, 1'b0);
        cw = {NCH{10'h3E0}};
        stream(20, 1, cw, 1'b0);
        repeat (3) begin
            cycle(1'b1, cw, 3'b001, 1'b0, 1'b0);
            stream(6, 1, cw, 1'b0);
        end
        stream(20, 1, cw, 1'b0);
        repeat (8) begin
            cycle(1'b1, cw, 3'b001, 1'b0, 1'b0);
            stream(3, 1, cw, 1'b0);
        end
        stream(20, 1, cw, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1);
        stream(7, 0, '0, 1'b0);
        stream(20, 0, '0, 1'b1);
        stream(13, 0, '0, 1'b0);
        repeat (5) cycle(1'b0, mkw(wk), '0, 1'b0, 1'b0);
        stream(15, 0, '0, 1'b0);
        repeat (8) cycle(1'b0, '0, '0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hdmi_gearbox.md
# hdmi_gearbox

Parametrised multi-channel TMDS gearbox for the HDMI transmit path. It accepts NCH parallel 10-bit encoded words per transfer and emits a continuous stream of OW-bit words, MSB-first, so that narrower serializers (4:1 or 8:1) can be driven from one fabric clock. It also adds two features the fixed 10:1 output path lacks:

- per-channel runtime bit-slip for lane alignment;
- a training-pattern override.

It sits between the TMDS encoders and the per-lane serializer primitives.

## Interface
- NCH, 3: number of TMDS channels, all processed in lockstep.
- IW, 10: input word width per channel.
- OW, 8: output word width per channel; legal range 1 ≤ OW ≤ IW.
- OPT_BITREVERSE, 1'b0: bit-reverse each input word before any other processing.
- TRAIN_WORD, 10'h354: IW-bit word substituted on every channel while i_train is high.
- i_clk  input  1  the single clock for all logic.
- i_reset  input  1  reset, synchronous and active-high.
- i_valid  input  1  i_word holds a new transfer.
- o_ready  output  1  the block accepts i_word this cycle (combinational).
- i_word  input  NCH*IW  channel c occupies bits [c*IW +: IW]; bit IW-1 is transmitted first.
- i_slip  input  NCH  a one-cycle pulse adds one bit of delay to channel c.
- i_train  input  1  replace every accepted word with TRAIN_WORD.
- o_valid  output  1  o_word holds new data.
- o_word  output  NCH*OW  channel c occupies bits [c*OW +: OW]; bit OW-1 is transmitted first.
- o_underflow  output  1  one-cycle pulse marking a cycle with no output word while in RUN.

## Operation
- Per-channel shift buffer of BW = 2*IW bits, left-aligned. Valid bits occupy buf[BW-1 -: fill].
- One fill counter is shared by all channels, width $clog2(BW+1).
- Per-cycle combinational terms:
  - emit = (fill ≥ OW).
  - fill_e = fill − (emit ? OW : 0).
  - o_ready = (fill_e + IW ≤ BW) and not i_reset.
  - accept = i_valid and o_ready.
- On emit: o_word[c] ← buf[BW-1 -: OW], and every buffer shifts left by OW.
- On accept: the processed word is written at buf[BW-1-fill_e -: IW], into the post-shift buffer.
- fill ← fill_e + (accept ? IW : 0).
- Input processing order per channel:
  1. Optional bit reverse.
  2. Training substitution.
  3. Bit delay.
- Bit delay, per channel:
  - Delay d ranges 0..IW-1; each i_slip[c] pulse sets d ← (d+1) mod IW, so the value wraps IW-1 → 0.
  - Delayed word = {prev[d-1:0], cur[IW-1:d]}; with d = 0 the word passes unchanged.
  - prev ← cur (pre-delay word) on each accept only.
  - A change to d takes effect on the next accepted word; a slip coinciding with an accept applies to the following word.
- State machine:
  - PRIME (entered on reset): o_underflow is forced low. Move to RUN on the first cycle where emit = 1.
  - RUN: any cycle with emit = 0 gives o_valid = 0 and o_underflow = 1 on the next cycle. RUN persists until reset.
- Steady-state input acceptance rate is OW/IW transfers per cycle. With OW = IW, o_ready stays high once primed.

## Timing
- Output latency: o_word and o_valid are registered one cycle after the emit decision.
- First output: a word accepted in cycle t appears on o_word in cycle t+2, provided IW ≥ OW. The word is written in t, emit is seen in t+1, and the output is registered at the end of t+1.
- o_ready is combinational from fill only and never depends on i_valid.
- Reset clears all state:
  - fill = 0, buf = 0, prev = 0, all d = 0, state = PRIME;
  - o_valid = 0, o_word = 0, o_underflow = 0.
- Reset mid-stream discards all buffered bits. No partial word is emitted after reset.
- i_train is sampled per accepted transfer. Toggling it never drops or duplicates bits.

## Structure
- Shared package hdmi_pkg holds:
  - the TMDS control-token constants (0x354, 0x0AB, 0x154, 0x2AB), with TRAIN_WORD defaulting to the first;
  - the channel-index constants used across HDMI blocks.
- Sub-module hdmi_bitslip, one instance per channel, contains the d counter, the prev register and the delay mux. It has ports i_clk, i_reset, i_ce (accept), i_slip, i_word and o_word (combinational output).
- The gearbox core holds the buffers, the fill counter, the state machine and the output registers.

## Test plan
- **10:8 stream (NCH=3, IW=10, OW=8):** i_valid held high with an incrementing word pattern.
  - o_valid = 1 on every cycle from the first output.
  - o_ready shows a 4-of-5 acceptance pattern.
  - The concatenated output bitstream equals the input bitstream, MSB-first, for 1000 words.
- **Bit-slip:** constant input 10'h3E0; pulse i_slip[0] three times.
  - Channel 0 bitstream is shifted by exactly 3 bits relative to channels 1 and 2.
  - Eleven pulses in total wrap d to 1.
- **Training:** assert i_train for 20 transfers.
  - Every channel carries the repeating stream 10'h354 with no lost or extra bits at either edge.
- **Underflow:** drop i_valid for 5 cycles while in RUN.
  - o_underflow pulses once per cycle with emit = 0.
  - No o_underflow pulses occur in PRIME after reset.
- **OW=IW=10 configuration:** o_ready is high every cycle and o_word[c] equals i_word[c] with 2-cycle latency.
- **Mid-stream reset:** assert i_reset with fill = 12.
  - Next cycle: all outputs are 0 and fill = 0.
  - The first word after reset emerges intact at t+2.
